// File: rtl/cee_cfg_pkg.sv
// cee_cfg_pkg: widths, FSM states and frame builder for cee_cfg_serializer (CEE_CFG_PARITY_EN appends even parity)
package cee_cfg_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 15;
  localparam int WORD_W = ADDR_W + DATA_W;
`ifdef CEE_CFG_PARITY_EN
  localparam int FRAME_W = WORD_W + 1;
`else
  localparam int FRAME_W = WORD_W;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, GAP} state_t;
  function automatic logic [FRAME_W-1:0] build_frame(input logic [WORD_W-1:0] w);
`ifdef CEE_CFG_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction
endpackage

// File: rtl/cee_cfg_fifo.sv
// cee_cfg_fifo: first-word-fall-through synchronous FIFO; a push into a full FIFO is taken only alongside a pop
module cee_cfg_fifo #(
  parameter int W     = 23,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout  = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(wr);
      rp  <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/cee_cfg_serializer.sv
// cee_cfg_serializer: queues SPI config words on cfg_valid rising edges and shifts them MSB-first onto sck/sdo/ld
// Build option: CEE_CFG_PARITY_EN appends an even-parity bit to every frame.
module cee_cfg_serializer
  import cee_cfg_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              sys_clk_i,
  input  logic              sys_rstn_i,
  input  logic              cfg_valid,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              ovf_clr_i,
  output logic              sck_o,
  output logic              sdo_o,
  output logic              ld_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic [7:0]        frame_cnt_o
);
  localparam int BW = $clog2(FRAME_W);
  localparam logic [8:0] HALF_END = 9'(DIV - 1);
  localparam logic [8:0] LOAD_END = 9'(2 * DIV - 1);
  state_t state, state_n;
  logic v_q, push_req, push, pop, full, empty, hi, hi_n, frame_done;
  logic [WORD_W-1:0] dout;
  logic [FRAME_W-1:0] sr, sr_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [8:0] div_cnt, div_n;
  assign push_req = cfg_valid & ~v_q;
  assign push     = push_req & (~full | pop);
  assign busy_o   = (state != IDLE) | ~empty;
  cee_cfg_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (sys_clk_i),
    .rst_n(sys_rstn_i),
    .push (push),
    .pop  (pop),
    .din  ({cfg_addr, cfg_data}),
    .full (full),
    .empty(empty),
    .dout (dout)
  );
  // hi selects the sck-high half of the current bit; div_cnt times each half and the load strobe
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    bit_n      = bit_cnt;
    div_n      = div_cnt + 9'd1;
    hi_n       = hi;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        div_n = '0;
        hi_n  = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          sr_n    = build_frame(dout);
          bit_n   = BW'(FRAME_W - 1);
          state_n = SHIFT;
        end
      end
      SHIFT: if (div_cnt == HALF_END) begin
        div_n = '0;
        hi_n  = ~hi;
        if (hi && bit_cnt == '0) state_n = LOAD;
        else if (hi) begin
          sr_n  = sr << 1;
          bit_n = bit_cnt - 1'b1;
        end
      end
      LOAD: if (div_cnt == LOAD_END) begin
        div_n      = '0;
        frame_done = 1'b1;
        state_n    = GAP;
      end
      default: begin
        div_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  // serial outputs are registered copies of the next state so they carry no decode glitches
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i)
    if (!sys_rstn_i) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      div_cnt     <= '0;
      hi          <= 1'b0;
      v_q         <= 1'b0;
      sck_o       <= 1'b0;
      sdo_o       <= 1'b0;
      ld_o        <= 1'b0;
      ovf_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bit_cnt     <= bit_n;
      div_cnt     <= div_n;
      hi          <= hi_n;
      v_q         <= cfg_valid;
      sck_o       <= state_n == SHIFT && hi_n;
      sdo_o       <= state_n == SHIFT && sr_n[FRAME_W-1];
      ld_o        <= state_n == LOAD;
      ovf_o       <= (push_req & full & ~pop) | (ovf_o & ~ovf_clr_i);
      frame_cnt_o <= frame_cnt_o + 8'(frame_done);
    end
endmodule

// File: tb/tb_cee_cfg_serializer.sv
// tb_cee_cfg_serializer: randomized scenarios for cee_cfg_serializer checked against a frame-level reference model
module tb_cee_cfg_serializer;
`ifdef CEE_CFG_PARITY_EN
  localparam int FW = 24;
`else
  localparam int FW = 23;
`endif
  localparam int DIV = 4;
  typedef struct {logic [23:0] bits; int n; int ld;} rxf_t;
  typedef struct {logic [7:0] a; logic [14:0] d;} word_t;
  logic sys_clk_i = 0, sys_rstn_i = 0, cfg_valid = 0, ovf_clr_i = 0;
  logic [7:0] cfg_addr = 0;
  logic [14:0] cfg_data = 0;
  logic sck_o, sdo_o, ld_o, busy_o, ovf_o;
  logic [7:0] frame_cnt_o;
  int checks = 0, errors = 0, exp_fc = 0, nb = 0, ldlen = 0, ld_seen = 0;
  logic [23:0] acc = 0;
  logic sck_p = 0, sdo_p = 0, ld_p = 0;
  rxf_t rxq[$];
  word_t sent[$];

  always #5 sys_clk_i = ~sys_clk_i;

  cee_cfg_serializer #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
    .sys_clk_i(sys_clk_i), .sys_rstn_i(sys_rstn_i), .cfg_valid(cfg_valid),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .ovf_clr_i(ovf_clr_i),
    .sck_o(sck_o), .sdo_o(sdo_o), .ld_o(ld_o), .busy_o(busy_o),
    .ovf_o(ovf_o), .frame_cnt_o(frame_cnt_o)
  );

  // expected bit stream: address MSB first, data LSB last, then even parity when enabled
  function automatic logic [23:0] exp_frame(input logic [7:0] a, input logic [14:0] d);
    logic [22:0] w;
    int ones;
    w = {a, d};
    ones = 0;
    for (int i = 0; i < 23; i++) ones += int'(w[i]);
`ifdef CEE_CFG_PARITY_EN
    return {w, ones % 2 == 1};
`else
    return {1'b0, w};
`endif
  endfunction

  // frame monitor: sdo captured on sck rises, frame closed on ld fall
  initial forever begin
    rxf_t f;
    @(negedge sys_clk_i);
    if (!sys_rstn_i) begin
      acc = 0; nb = 0; ldlen = 0; sck_p = 0; sdo_p = 0; ld_p = 0;
    end else begin
      if (sck_o && !sck_p) begin acc = {acc[22:0], sdo_o}; nb++; end
      if (sck_o && sck_p) begin
        checks++;
        if (sdo_o !== sdo_p) begin errors++; $display("FAIL sdo_stable: sdo %b changed from %b while sck high", sdo_o, sdo_p); end
      end
      if (ld_o) begin
        ldlen++; ld_seen++; checks++;
        if (sck_o !== 1'b0) begin errors++; $display("FAIL sck_during_ld: sck %b expected 0", sck_o); end
      end
      if (!ld_o && ld_p) begin
        f.bits = acc; f.n = nb; f.ld = ldlen;
        rxq.push_back(f);
        acc = 0; nb = 0; ldlen = 0;
      end
      sck_p = sck_o; sdo_p = sdo_o; ld_p = ld_o;
    end
  end

  task automatic pulse(input logic [7:0] a, input logic [14:0] d, input int low, input logic clr);
    @(posedge sys_clk_i); #1;
    cfg_valid = 1; cfg_addr = a; cfg_data = d; ovf_clr_i = clr;
    @(posedge sys_clk_i); #1;
    cfg_valid = 0; ovf_clr_i = 0;
    repeat (low - 1) @(posedge sys_clk_i);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    @(negedge sys_clk_i);
    while (busy_o && n < max) begin @(negedge sys_clk_i); n++; end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL wait_idle: busy %b after %0d cycles, expected 0", busy_o, n); end
  endtask

  task automatic do_reset();
    cfg_valid = 0; ovf_clr_i = 0; sys_rstn_i = 0;
    repeat (3) @(negedge sys_clk_i);
    @(posedge sys_clk_i); #1 sys_rstn_i = 1;
    exp_fc = 0;
    rxq.delete();
  endtask

  task automatic test_reset();
    sys_rstn_i = 0;
    repeat (3) @(negedge sys_clk_i);
    checks += 2;
    if ({sck_o, sdo_o, ld_o, busy_o, ovf_o} !== 5'b0) begin errors++; $display("FAIL reset_outs: %b expected 00000", {sck_o, sdo_o, ld_o, busy_o, ovf_o}); end
    if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: %0d expected 0", frame_cnt_o); end
    @(posedge sys_clk_i); #1 sys_rstn_i = 1;
    repeat (3) @(negedge sys_clk_i);
    checks++;
    if ({sck_o, sdo_o, ld_o, busy_o, ovf_o, frame_cnt_o} !== 13'b0) begin errors++; $display("FAIL post_reset_idle: %b expected all 0", {sck_o, sdo_o, ld_o, busy_o, ovf_o, frame_cnt_o}); end
    exp_fc = 0;
    rxq.delete();
  endtask

  task automatic test_single_frame();
    int k = 0, busy_n = 0;
    logic sdo2 = 0, sck2 = 1;
    @(posedge sys_clk_i); #1;
    cfg_valid = 1; cfg_addr = 8'hA5; cfg_data = 15'h1234;
    while (k < 400) begin
      @(negedge sys_clk_i);
      if (k == 2) begin sdo2 = sdo_o; sck2 = sck_o; end
      if (busy_o) busy_n++;
      else if (busy_n > 0) break;
      k++;
    end
    cfg_valid = 0;
    exp_fc++;
    checks += 3;
    if (sdo2 !== 1'b1 || sck2 !== 1'b0) begin errors++; $display("FAIL first_bit_latency: sdo %b sck %b two cycles after edge, expected 1 0", sdo2, sck2); end
    // busy covers the pop cycle plus the 193-cycle frame
    if (busy_n != 194) begin errors++; $display("FAIL frame_time: busy %0d cycles expected 194", busy_n); end
    if (frame_cnt_o !== 8'(exp_fc)) begin errors++; $display("FAIL single_cnt: %0d expected %0d", frame_cnt_o, exp_fc); end
    checks++;
    if (rxq.size() != 1) begin errors++; $display("FAIL single_frames: %0d frames expected 1", rxq.size()); end
    else begin
      checks += 3;
      if (rxq[0].bits !== exp_frame(8'hA5, 15'h1234)) begin errors++; $display("FAIL single_bits: %h expected %h", rxq[0].bits, exp_frame(8'hA5, 15'h1234)); end
      if (rxq[0].n != FW) begin errors++; $display("FAIL single_nbits: %0d expected %0d", rxq[0].n, FW); end
      if (rxq[0].ld != 2 * DIV) begin errors++; $display("FAIL single_ld_len: %0d expected %0d", rxq[0].ld, 2 * DIV); end
    end
    rxq.delete();
  endtask

  task automatic test_held_level();
    logic [7:0] a = 8'($urandom);
    logic [14:0] d = 15'($urandom);
    @(posedge sys_clk_i); #1;
    cfg_valid = 1; cfg_addr = a; cfg_data = d;
    repeat (1000) begin @(posedge sys_clk_i); #1; cfg_addr = 8'($urandom); cfg_data = 15'($urandom); end
    cfg_valid = 0;
    wait_idle(400);
    exp_fc++;
    checks += 3;
    if (rxq.size() != 1) begin errors++; $display("FAIL held_frames: %0d frames expected 1", rxq.size()); end
    else if (rxq[0].bits !== exp_frame(a, d)) begin errors++; $display("FAIL held_bits: %h expected %h", rxq[0].bits, exp_frame(a, d)); end
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL held_ovf: %b expected 0", ovf_o); end
    if (frame_cnt_o !== 8'(exp_fc)) begin errors++; $display("FAIL held_cnt: %0d expected %0d", frame_cnt_o, exp_fc); end
    rxq.delete();
  endtask

  // bursts finish long before the first frame does, so the FIFO holds at most one popped word plus four queued
  task automatic test_overflow();
    for (int r = 0; r < 6; r++) begin
      int k = (r == 0) ? 6 : $urandom_range(1, 6);
      int expn = (k > 5) ? 5 : k;
      word_t w;
      sent.delete(); rxq.delete();
      for (int i = 0; i < k; i++) begin
        w.a = 8'($urandom); w.d = 15'($urandom);
        sent.push_back(w);
        pulse(w.a, w.d, (r == 0) ? 1 : $urandom_range(1, 5), r == 0 && i == 5);
      end
      @(negedge sys_clk_i);
      checks++;
      if (ovf_o !== (k == 6)) begin errors++; $display("FAIL ovf_set r%0d: %b expected %b (k=%0d)", r, ovf_o, k == 6, k); end
      wait_idle(1200);
      exp_fc += expn;
      checks += 2;
      if (rxq.size() != expn) begin errors++; $display("FAIL ovf_frames r%0d: %0d expected %0d", r, rxq.size(), expn); end
      else for (int i = 0; i < expn; i++) begin
        checks++;
        if (rxq[i].bits !== exp_frame(sent[i].a, sent[i].d)) begin errors++; $display("FAIL ovf_bits r%0d f%0d: %h expected %h", r, i, rxq[i].bits, exp_frame(sent[i].a, sent[i].d)); end
      end
      if (frame_cnt_o !== 8'(exp_fc)) begin errors++; $display("FAIL ovf_cnt r%0d: %0d expected %0d", r, frame_cnt_o, 8'(exp_fc)); end
      @(posedge sys_clk_i); #1 ovf_clr_i = 1;
      @(posedge sys_clk_i); #1 ovf_clr_i = 0;
      @(negedge sys_clk_i);
      checks++;
      if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clear r%0d: %b expected 0", r, ovf_o); end
    end
    rxq.delete();
  endtask

  task automatic test_reset_mid_frame();
    int n = 0, ld_snap;
    logic [7:0] a = 8'($urandom);
    logic [14:0] d = 15'($urandom);
    rxq.delete();
    pulse(a, d, 1, 0);
    while (nb < 10 && n < 400) begin @(negedge sys_clk_i); n++; end
    checks++;
    if (nb < 10) begin errors++; $display("FAIL mid_reach_bit10: %0d bits seen expected 10", nb); end
    ld_snap = ld_seen;
    #2 sys_rstn_i = 0;
    #1;
    checks += 2;
    if ({sck_o, sdo_o, ld_o, busy_o, ovf_o} !== 5'b0) begin errors++; $display("FAIL mid_async_outs: %b expected 00000", {sck_o, sdo_o, ld_o, busy_o, ovf_o}); end
    if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL mid_async_cnt: %0d expected 0", frame_cnt_o); end
    repeat (2) @(negedge sys_clk_i);
    @(posedge sys_clk_i); #1 sys_rstn_i = 1;
    exp_fc = 0;
    repeat (300) @(negedge sys_clk_i);
    checks += 2;
    if (ld_seen != ld_snap) begin errors++; $display("FAIL mid_no_ld: %0d ld cycles after reset expected 0", ld_seen - ld_snap); end
    if (rxq.size() != 0) begin errors++; $display("FAIL mid_no_frame: %0d frames expected 0", rxq.size()); end
    a = 8'($urandom); d = 15'($urandom);
    pulse(a, d, 1, 0);
    wait_idle(400);
    exp_fc++;
    checks += 2;
    if (rxq.size() != 1) begin errors++; $display("FAIL mid_next_frames: %0d expected 1", rxq.size()); end
    else if (rxq[0].bits !== exp_frame(a, d) || rxq[0].n != FW) begin errors++; $display("FAIL mid_next_bits: %h/%0d expected %h/%0d", rxq[0].bits, rxq[0].n, exp_frame(a, d), FW); end
    if (frame_cnt_o !== 8'(exp_fc)) begin errors++; $display("FAIL mid_next_cnt: %0d expected %0d", frame_cnt_o, exp_fc); end
    rxq.delete();
  endtask

  task automatic test_frame_cnt_wrap();
    word_t w;
    do_reset();
    sent.delete();
    for (int i = 0; i < 256; i++) begin
      int n = 0;
      w.a = 8'($urandom); w.d = 15'($urandom);
      sent.push_back(w);
      pulse(w.a, w.d, 1, 0);
      while (ld_o && n < 500) begin @(negedge sys_clk_i); n++; end
      while (!ld_o && n < 500) begin @(negedge sys_clk_i); n++; end
      if (n >= 500) begin checks++; errors++; $display("FAIL wrap_timeout: frame %0d ld never rose", i); break; end
      if (i == 255) begin
        checks++;
        if (frame_cnt_o !== 8'd255) begin errors++; $display("FAIL wrap_cnt255: %0d expected 255", frame_cnt_o); end
      end
    end
    wait_idle(400);
    checks += 2;
    if (frame_cnt_o !== 8'd0) begin errors++; $display("FAIL wrap_cnt0: %0d expected 0", frame_cnt_o); end
    if (rxq.size() != 256) begin errors++; $display("FAIL wrap_frames: %0d expected 256", rxq.size()); end
    else for (int i = 0; i < 256; i++) begin
      checks++;
      if (rxq[i].bits !== exp_frame(sent[i].a, sent[i].d)) begin errors++; $display("FAIL wrap_bits f%0d: %h expected %h", i, rxq[i].bits, exp_frame(sent[i].a, sent[i].d)); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_held_level();
    test_overflow();
    test_reset_mid_frame();
    test_frame_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
